fifo_read_unpacker: RTL and testbench
=====================================

Name: fifo_read_unpacker

Overview:
- Sits on the read side (clk_out domain) of the 140-bit async_fifo.
- Drains the FIFO one word at a time using fifo_r_enable, fifo_empty and data_from_fifo.
- Slices each captured word into OUT_W-bit beats on a valid/ready stream for the downstream datapath.
- Provides the consumer end of the FIFO interface that the write-side logic feeds.

Parameters:
- DW, 140: FIFO word width; must match the async_fifo instance.
- OUT_W, 32: output beat width; must satisfy 1 <= OUT_W <= DW.
- CNT_W, 16: width of the consumed-word counter.

Ports:
- clk_out  in  1  read-domain clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag, already in the clk_out domain.
- data_from_fifo  in  DW  FIFO read data; valid in the cycle after fifo_r_enable is sampled high.
- fifo_r_enable  out  1  FIFO pop strobe; single-cycle pulse.
- out_data  out  OUT_W  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of the word.
- out_vbits  out  $clog2(OUT_W+1)  number of valid LSBs in out_data.
- word_cnt  out  CNT_W  count of words fully emitted; wraps modulo 2^CNT_W.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock domain, synchronous active-high reset.
- Reset:
  - rst sampled high forces state to IDLE on that edge.
  - All outputs are 0 while rst is high and in the cycle after.
  - beat_idx=0, word_cnt=0, capture register=0.
- Derived constants:
  - NBEATS = ceil(DW/OUT_W); defaults give 5.
  - LAST_VB = DW-(NBEATS-1)*OUT_W; defaults give 12.
- FSM, with fifo_r_enable and out_valid as registered/Moore outputs:
  - IDLE: if fifo_empty==0, go to RD; else stay in IDLE.
  - RD: fifo_r_enable=1 for exactly this cycle; go to CAP. fifo_empty is ignored in RD.
  - CAP: capture register <= data_from_fifo; beat_idx <= 0; go to SEND.
  - SEND: out_valid=1; out_data = capture[beat_idx*OUT_W +: OUT_W], with bits at or above DW driven 0.
    - out_last = (beat_idx==NBEATS-1).
    - out_vbits = out_last ? LAST_VB : OUT_W.
    - On out_valid && out_ready: if not last, beat_idx++; if last, word_cnt++ and go to IDLE.
- Beat order: LSB first, so beat 0 is bits [OUT_W-1:0].
- Handshake:
  - out_data, out_last and out_vbits stay stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- Latency: fifo_empty seen low at edge k gives fifo_r_enable high in cycle k+1 and first out_valid in cycle k+3.
- Throughput with out_ready held high: one word per NBEATS+3 cycles (8 at defaults).
- FIFO safety:
  - fifo_r_enable is never asserted unless fifo_empty was 0 at the preceding edge.
  - Never more than one pop is outstanding.
- Reset mid-operation: a word already popped (RD, CAP or SEND) is discarded and not retried. Downstream must tolerate a truncated word with no out_last.
- word_cnt wraps from 2^CNT_W-1 to 0.
- If OUT_W divides DW exactly, LAST_VB = OUT_W.

Decomposition:
- Package fifo_rd_pkg:
  - localparam DW=140.
  - Function nbeats(dw, ow) and function last_vbits(dw, ow).
  - typedef enum logic [1:0] {IDLE, RD, CAP, SEND} rd_state_t.
- No sub-module: the FSM, beat mux and counter stay in a single module.

Test Plan:
- Reset: rst high for 4 cycles with fifo_empty=0 -> fifo_r_enable=0, out_valid=0, busy=0, word_cnt=0 throughout. First fifo_r_enable appears 2 cycles after rst falls.
- Single word: data_from_fifo = 140'h0_ABC_DEADBEEF_01234567_89ABCDEF_FEEDFACE with out_ready=1 -> exactly one fifo_r_enable pulse. Then 5 beats: FEEDFACE, 89ABCDEF, 01234567, DEADBEEF, 00000ABC. Beat 5 has out_last=1 and out_vbits=12. word_cnt=1, then back to IDLE.
- Backpressure: out_ready follows pattern 0,0,1,0,1,1,0,1,1 -> each beat held stable until accepted. Exactly 5 handshakes with values identical to the single-word case, and no extra FIFO pops.
- Back-to-back: fifo_empty held 0 for two words, out_ready=1 -> fifo_r_enable pulses exactly 8 cycles apart. 10 beats total, word_cnt=2.
- Empty hold: fifo_empty=1 for 50 cycles -> fifo_r_enable=0, out_valid=0 and busy=0 for all 50 cycles.
- Reset mid-word: rst asserted during beat 2 of word A -> out_valid=0 next cycle. After release, word B starts at beat 0, word A's remaining beats are never emitted, and word_cnt restarts from 0.

Source files
------------

// File: rtl/fifo_read_unpacker_pkg.sv
// Shared definitions for the async-FIFO read-side unpacker: FIFO word width,
// beat-count helpers and the read FSM state encoding.
package fifo_rd_pkg;

   localparam int DW = 140;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      CAP,
      SEND
   } rd_state_t;

   function automatic int nbeats(input int dw, input int ow);
      return (dw + ow - 1) / ow;
   endfunction

   // Width of the final, possibly partial, beat of a word.
   function automatic int last_vbits(input int dw, input int ow);
      return dw - (nbeats(dw, ow) - 1) * ow;
   endfunction

endpackage

// File: rtl/fifo_read_unpacker.sv
// Read-side consumer of the async FIFO: pops one word at a time, then streams
// it LSB-first as OUT_W-bit beats over a valid/ready interface.
module fifo_read_unpacker #(
   parameter int DW    = fifo_rd_pkg::DW,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
) (
   input  logic                       clk_out,
   input  logic                       rst,
   input  logic                       fifo_empty,
   input  logic [DW-1:0]              data_from_fifo,
   output logic                       fifo_r_enable,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last,
   output logic [$clog2(OUT_W+1)-1:0] out_vbits,
   output logic [CNT_W-1:0]           word_cnt,
   output logic                       busy
);
   import fifo_rd_pkg::*;

   localparam int NBEATS  = nbeats(DW, OUT_W);
   localparam int LAST_VB = last_vbits(DW, OUT_W);
   localparam int VB_W    = $clog2(OUT_W + 1);
   localparam int BIDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int PAD_W   = NBEATS * OUT_W;

   rd_state_t         state_q, state_d;
   logic [BIDX_W-1:0] beat_q,  beat_d;
   logic [DW-1:0]     cap_q,   cap_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic [PAD_W-1:0]  cap_pad;
   logic [OUT_W-1:0]  beat_w [NBEATS];
   logic              in_send;
   logic              is_last;

   // Zero-extend so the top beat reads 0 above bit DW-1.
   assign cap_pad = PAD_W'(cap_q);

   for (genvar g = 0; g < NBEATS; g++) begin : g_beat
      assign beat_w[g] = cap_pad[g*OUT_W +: OUT_W];
   end

   assign in_send = (state_q == SEND);
   assign is_last = (beat_q == BIDX_W'(NBEATS - 1));

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = RD;
            end
         end
         RD: begin
            state_d = CAP;
         end
         CAP: begin
            cap_d   = data_from_fifo;
            beat_d  = '0;
            state_d = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (is_last) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + BIDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_out) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
      end
   end

   // All outputs decode the state register only, so nothing combinational
   // leaks from fifo_empty or out_ready to the outputs.
   assign fifo_r_enable = (state_q == RD);
   assign out_valid     = in_send;
   assign out_data      = in_send ? beat_w[beat_q] : '0;
   assign out_last      = in_send && is_last;
   assign out_vbits     = !in_send ? '0 : (is_last ? VB_W'(LAST_VB) : VB_W'(OUT_W));
   assign word_cnt      = cnt_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_read_unpacker.sv
// Scoreboard bench for fifo_read_unpacker: a FIFO model feeds words, expected
// beats are queued at push time and a monitor checks every handshake.
module tb_fifo_read_unpacker;

   localparam int DW    = 140;
   localparam int OUT_W = 32;
   localparam int CNT_W = 16;
   localparam int VB_W  = 6;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             last;
      logic [VB_W-1:0]  vb;
   } beat_t;

   logic             clk;
   logic             rst;
   logic             fifo_empty;
   logic [DW-1:0]    data_from_fifo;
   logic             fifo_r_enable;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [VB_W-1:0]  out_vbits;
   logic [CNT_W-1:0] word_cnt;
   logic             busy;

   beat_t         exp_q[$];
   logic [DW-1:0] fq[$];
   int            pop_cyc[$];
   int            vectors     = 0;
   int            miscompares = 0;
   int            pops        = 0;
   int            hs          = 0;
   int            cyc         = 0;

   localparam logic [DW-1:0] W1 = 140'hABC_DEADBEEF_01234567_89ABCDEF_FEEDFACE;
   localparam logic [DW-1:0] W2 = 140'h123_00000004_00000003_00000002_00000001;
   localparam logic [DW-1:0] W3 = 140'hFFF_CAFEF00D_A5A5A5A5_5A5A5A5A_0F0F0F0F;

   fifo_read_unpacker #(.DW(DW), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk_out        (clk),
      .rst            (rst),
      .fifo_empty     (fifo_empty),
      .data_from_fifo (data_from_fifo),
      .fifo_r_enable  (fifo_r_enable),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .out_vbits      (out_vbits),
      .word_cnt       (word_cnt),
      .busy           (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w,
                            input logic [OUT_W-1:0] b0, input logic [OUT_W-1:0] b1,
                            input logic [OUT_W-1:0] b2, input logic [OUT_W-1:0] b3,
                            input logic [OUT_W-1:0] b4);
      fq.push_back(w);
      exp_q.push_back(beat_t'{b0, 1'b0, 6'd32});
      exp_q.push_back(beat_t'{b1, 1'b0, 6'd32});
      exp_q.push_back(beat_t'{b2, 1'b0, 6'd32});
      exp_q.push_back(beat_t'{b3, 1'b0, 6'd32});
      exp_q.push_back(beat_t'{b4, 1'b1, 6'd12});
   endtask

   task automatic wait_cnt(input logic [CNT_W-1:0] tgt, input string name);
      int n;
      n = 0;
      while (!(word_cnt == tgt && busy == 1'b0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_done_in_time"}, (n < 200), 1'b1);
      check({name, "_word_cnt"}, word_cnt, tgt);
   endtask

   // FIFO model: data appears the cycle after a pop is sampled.
   initial begin : fifo_model
      logic re_s, re_prev, emp_prev;
      fifo_empty     = 1'b1;
      data_from_fifo = '0;
      re_prev        = 1'b0;
      emp_prev       = 1'b1;
      forever begin
         @(negedge clk);
         re_s = (fifo_r_enable === 1'b1);
         if (re_s) begin
            pops++;
            pop_cyc.push_back(cyc);
            check("pop_requires_nonempty", emp_prev, 1'b0);
            check("pop_single_cycle", re_prev, 1'b0);
         end
         re_prev  = re_s;
         emp_prev = fifo_empty;
         @(posedge clk); #1;
         if (re_s) begin
            if (fq.size() > 0) begin
               data_from_fifo = fq.pop_front();
            end else begin
               vectors++;
               miscompares++;
               $display("FAIL pop_underflow: got pop, expected none (fifo empty)");
            end
         end
         fifo_empty = (fq.size() == 0);
      end
   end

   initial begin : monitor
      beat_t e, held;
      logic  stall_prev, rst_prev;
      stall_prev = 1'b0;
      rst_prev   = 1'b1;
      held       = '0;
      forever begin
         @(negedge clk);
         if (stall_prev && !rst_prev) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_beat", {out_data, out_last, out_vbits}, held);
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            hs++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got %0h, expected no beat", out_data);
            end else begin
               e = exp_q.pop_front();
               check("beat", {out_data, out_last, out_vbits}, e);
            end
         end
         stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
         held       = {out_data, out_last, out_vbits};
         rst_prev   = rst;
      end
   end

   initial begin : stim
      logic [8:0] pat;
      int base_h, base_p, base_c, n;
      pat       = 9'b110110100;
      rst       = 1'b1;
      out_ready = 1'b1;

      // Reset with a word waiting in the FIFO
      push_word(W1, 32'hFEEDFACE, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h00000ABC);
      @(posedge clk); #1;
      repeat (4) begin
         @(posedge clk); #1;
         check("rst_ren", fifo_r_enable, 1'b0);
         check("rst_valid", out_valid, 1'b0);
         check("rst_busy", busy, 1'b0);
         check("rst_wcnt", word_cnt, '0);
      end
      rst = 1'b0;
      check("post_rst_outputs",
            {fifo_r_enable, out_valid, out_last, out_vbits, out_data, busy, word_cnt}, '0);
      @(posedge clk); #1;
      check("first_ren", fifo_r_enable, 1'b1);
      check("first_busy", busy, 1'b1);
      wait_cnt(16'd1, "single");
      check("single_pops", pops, 1);
      check("single_sb_empty", exp_q.size(), 0);

      // Backpressure
      out_ready = 1'b0;
      base_h = hs;
      base_p = pops;
      push_word(W1, 32'hFEEDFACE, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h00000ABC);
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_valid_seen", out_valid, 1'b1);
      for (int i = 0; i < 9; i++) begin
         out_ready = pat[i];
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      check("bp_handshakes", hs - base_h, 5);
      check("bp_pops", pops - base_p, 1);
      wait_cnt(16'd2, "bp");

      // Back-to-back words
      base_h = hs;
      base_p = pop_cyc.size();
      push_word(W2, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000123);
      push_word(W3, 32'h0F0F0F0F, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hCAFEF00D, 32'h00000FFF);
      wait_cnt(16'd4, "b2b");
      check("b2b_pops", pop_cyc.size() - base_p, 2);
      if (pop_cyc.size() >= base_p + 2) begin
         check("b2b_pop_spacing", pop_cyc[base_p+1] - pop_cyc[base_p], 8);
      end
      check("b2b_handshakes", hs - base_h, 10);

      // Empty hold
      base_p = pops;
      repeat (50) begin
         @(posedge clk); #1;
         check("empty_idle", {fifo_r_enable, out_valid, busy}, 3'b000);
      end
      check("empty_no_pops", pops - base_p, 0);

      // Reset in the middle of word A
      base_h = hs;
      push_word(W2, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000123);
      n = 0;
      while (hs != base_h + 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("mid_beat2_data", out_data, 32'h00000003);
      rst       = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_wcnt", word_cnt, '0);
      rst = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("mid_post_rst_ren", fifo_r_enable, 1'b0);
      base_h = hs;
      push_word(W1, 32'hFEEDFACE, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h00000ABC);
      wait_cnt(16'd1, "after_rst");
      check("after_rst_handshakes", hs - base_h, 5);

      repeat (3) @(posedge clk);
      #1;
      check("final_sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
